// File: rtl/sprite_frame_plotter.sv
// rtl/sprite_frame_plotter.sv - per-frame sprite erase/draw pixel sequencer
// Ports: clk, reset (sync, active-high); pause freezes sequencing; frame_start
// requests a frame (sampled in IDLE); sprite_x/y/colour/en are flat per-sprite
// buses; busy/frame_done handshake; x/y/colour/plot drive the VGA adapter.
module sprite_frame_plotter #(
    parameter int         NUM_SPRITES = 4,
    parameter int         SPR_W       = 4,
    parameter int         SPR_H       = 4,
    parameter int         X_BITS      = 8,
    parameter int         Y_BITS      = 7,
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter logic [2:0] BG_COLOUR   = 3'b000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pause,
    input  logic                          frame_start,
    input  logic [NUM_SPRITES*X_BITS-1:0] sprite_x,
    input  logic [NUM_SPRITES*Y_BITS-1:0] sprite_y,
    input  logic [NUM_SPRITES*3-1:0]      sprite_colour,
    input  logic [NUM_SPRITES-1:0]        sprite_en,
    output logic                          busy,
    output logic                          frame_done,
    output logic [X_BITS-1:0]             x,
    output logic [Y_BITS-1:0]             y,
    output logic [2:0]                    colour,
    output logic                          plot
);
    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic [NUM_SPRITES*X_BITS-1:0] new_x_q, new_x_d, prev_x_q, prev_x_d;
    logic [NUM_SPRITES*Y_BITS-1:0] new_y_q, new_y_d, prev_y_q, prev_y_d;
    logic [NUM_SPRITES*3-1:0]      new_colour_q, new_colour_d;
    logic [NUM_SPRITES-1:0]        new_en_q, new_en_d, prev_en_q, prev_en_d;

    logic [X_BITS-1:0] x_q, x_d;
    logic [Y_BITS-1:0] y_q, y_d;
    logic [2:0]        colour_q, colour_d;
    logic              plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    // Slot datapath: erase reads the previous snapshot, draw the new one.
    logic                          erasing;
    logic [NUM_SPRITES*X_BITS-1:0] sel_x;
    logic [NUM_SPRITES*Y_BITS-1:0] sel_y;
    logic [NUM_SPRITES-1:0]        sel_en;
    logic [X_BITS:0]               px;
    logic [Y_BITS:0]               py;
    logic                          slot_en, slot_vis, slot_last;

    assign erasing = (state_q == S_ERASE);
    assign sel_x   = erasing ? prev_x_q  : new_x_q;
    assign sel_y   = erasing ? prev_y_q  : new_y_q;
    assign sel_en  = erasing ? prev_en_q : new_en_q;
    assign slot_en = sel_en[idx_q];

    // One extra bit so base + offset never wraps before the clip test.
    assign px = {1'b0, sel_x[int'(idx_q)*X_BITS +: X_BITS]} + (X_BITS+1)'(col_q);
    assign py = {1'b0, sel_y[int'(idx_q)*Y_BITS +: Y_BITS]} + (Y_BITS+1)'(row_q);

    assign slot_vis  = slot_en && (px < (X_BITS+1)'(SCREEN_W)) && (py < (Y_BITS+1)'(SCREEN_H));
    // A disabled sprite occupies a single blank slot.
    assign slot_last = !slot_en || ((col_q == CW'(SPR_W-1)) && (row_q == RW'(SPR_H-1)));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        col_d        = col_q;
        row_d        = row_q;
        new_x_d      = new_x_q;
        new_y_d      = new_y_q;
        new_colour_d = new_colour_q;
        new_en_d     = new_en_q;
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        prev_en_d    = prev_en_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start && !pause) begin
                    new_x_d      = sprite_x;
                    new_y_d      = sprite_y;
                    new_colour_d = sprite_colour;
                    new_en_d     = sprite_en;
                    busy_d       = 1'b1;
                    idx_d        = '0;
                    col_d        = '0;
                    row_d        = '0;
                    state_d      = S_ERASE;
                end
            end
            S_ERASE, S_DRAW: begin
                if (!pause) begin
                    plot_d = slot_vis;
                    // Coordinates only update on real plots so clipped or
                    // blank slots never expose a truncated coordinate.
                    if (slot_vis) begin
                        x_d      = px[X_BITS-1:0];
                        y_d      = py[Y_BITS-1:0];
                        colour_d = erasing ? BG_COLOUR : new_colour_q[int'(idx_q)*3 +: 3];
                    end
                    if (slot_last) begin
                        col_d = '0;
                        row_d = '0;
                        if (idx_q == IW'(NUM_SPRITES-1)) begin
                            idx_d   = '0;
                            state_d = erasing ? S_DRAW : S_DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else if (col_q == CW'(SPR_W-1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                prev_x_d  = new_x_q;
                prev_y_d  = new_y_q;
                prev_en_d = new_en_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            new_x_q      <= '0;
            new_y_q      <= '0;
            new_colour_q <= '0;
            new_en_q     <= '0;
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            prev_en_q    <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            col_q        <= col_d;
            row_q        <= row_d;
            new_x_q      <= new_x_d;
            new_y_q      <= new_y_d;
            new_colour_q <= new_colour_d;
            new_en_q     <= new_en_d;
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            prev_en_q    <= prev_en_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
endmodule

// File: tb/tb_sprite_frame_plotter.sv
// tb/tb_sprite_frame_plotter.sv - self-checking bench for sprite_frame_plotter
module tb_sprite_frame_plotter;
    logic        clk = 1'b0;
    logic        reset, pause, frame_start;
    logic [31:0] sprite_x;
    logic [27:0] sprite_y;
    logic [11:0] sprite_colour;
    logic [3:0]  sprite_en;
    logic        busy, frame_done, plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;

    always #5 clk = ~clk;

    sprite_frame_plotter dut (
        .clk(clk), .reset(reset), .pause(pause), .frame_start(frame_start),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_colour(sprite_colour),
        .sprite_en(sprite_en), .busy(busy), .frame_done(frame_done),
        .x(x), .y(y), .colour(colour), .plot(plot)
    );

    typedef struct {bit p; int x; int y; int c;} slot_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    in_x[4], in_y[4], in_c[4];
    bit    in_en[4];
    int    cur_x[4], cur_y[4], cur_c[4];
    bit    cur_en[4];
    int    prev_x[4], prev_y[4];
    bit    prev_en[4];
    int    exp_x, exp_y, exp_c;
    slot_t q[$];
    int    n_erase;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            sprite_x[i*8 +: 8]      = in_x[i][7:0];
            sprite_y[i*7 +: 7]      = in_y[i][6:0];
            sprite_colour[i*3 +: 3] = in_c[i][2:0];
            sprite_en[i]            = in_en[i];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            prev_x[i] = 0; prev_y[i] = 0; prev_en[i] = 0;
        end
        exp_x = 0; exp_y = 0; exp_c = 0;
    endtask

    // Expected slot list: erase previous sprites, then draw new ones.
    task automatic build_expected();
        slot_t s;
        q.delete();
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 4; i++) begin
                bit en = ph ? cur_en[i] : prev_en[i];
                int bx = ph ? cur_x[i] : prev_x[i];
                int by = ph ? cur_y[i] : prev_y[i];
                if (!en) begin
                    s = '{0, 0, 0, 0};
                    q.push_back(s);
                end else begin
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++) begin
                            s.x = bx + c;
                            s.y = by + r;
                            s.p = (s.x < 160) && (s.y < 120);
                            s.c = ph ? cur_c[i] : 0;
                            q.push_back(s);
                        end
                end
            end
            if (ph == 0) n_erase = q.size();
        end
    endtask

    task automatic run_frame(input int pause_draw, input int pause_len,
                             input int pulse_at, input int abort_draw);
        drive_inputs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cur_x[i] = in_x[i]; cur_y[i] = in_y[i]; cur_c[i] = in_c[i]; cur_en[i] = in_en[i];
        end
        build_expected();
        n_tests++;
        if (busy !== 1'b1 || frame_done !== 1'b0 || plot !== 1'b0) begin
            n_fail++;
            $display("FAIL accept: busy=%0d done=%0d plot=%0d expected 1 0 0", busy, frame_done, plot);
        end
        // Disturb inputs; the frame must use the latched snapshot.
        for (int i = 0; i < 4; i++) begin
            in_x[i] = $urandom_range(0, 255); in_y[i] = $urandom_range(0, 127);
            in_c[i] = $urandom_range(0, 7);   in_en[i] = 1'($urandom_range(0, 1));
        end
        drive_inputs();
        for (int k = 0; k < q.size(); k++) begin
            if (abort_draw >= 0 && k == n_erase + abort_draw) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                n_tests++;
                if (busy !== 1'b0 || plot !== 1'b0 || frame_done !== 1'b0 ||
                    x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
                    n_fail++;
                    $display("FAIL abort_reset: busy=%0d plot=%0d done=%0d x=%0d y=%0d c=%0d expected all 0",
                             busy, plot, frame_done, x, y, colour);
                end
                model_reset();
                return;
            end
            if (k == pulse_at) frame_start = 1'b1;
            if (pause_draw >= 0 && k == n_erase + pause_draw) begin
                for (int p = 0; p < pause_len; p++) begin
                    pause = 1'b1;
                    step();
                    frame_start = 1'b0;
                    n_tests++;
                    if (plot !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0 ||
                        x !== 8'(exp_x) || y !== 7'(exp_y) || colour !== 3'(exp_c)) begin
                        n_fail++;
                        $display("FAIL pause_hold: plot=%0d busy=%0d x=%0d y=%0d c=%0d expected 0 1 %0d %0d %0d",
                                 plot, busy, x, y, colour, exp_x, exp_y, exp_c);
                    end
                end
                pause = 1'b0;
            end
            step();
            frame_start = 1'b0;
            n_tests++;
            if (busy !== 1'b1 || frame_done !== 1'b0 || plot !== q[k].p) begin
                n_fail++;
                $display("FAIL slot %0d: busy=%0d done=%0d plot=%0d expected 1 0 %0d",
                         k, busy, frame_done, plot, q[k].p);
            end
            if (q[k].p) begin
                exp_x = q[k].x; exp_y = q[k].y; exp_c = q[k].c;
                n_tests++;
                if (x !== 8'(exp_x) || y !== 7'(exp_y) || colour !== 3'(exp_c)) begin
                    n_fail++;
                    $display("FAIL pixel %0d: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                             k, x, y, colour, exp_x, exp_y, exp_c);
                end
            end
        end
        step();
        n_tests++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || plot !== 1'b0) begin
            n_fail++;
            $display("FAIL done: done=%0d busy=%0d plot=%0d expected 1 0 0", frame_done, busy, plot);
        end
        for (int i = 0; i < 4; i++) begin
            prev_x[i] = cur_x[i]; prev_y[i] = cur_y[i]; prev_en[i] = cur_en[i];
        end
    endtask

    task automatic check_idle(input string name);
        step();
        n_tests++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || plot !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy=%0d done=%0d plot=%0d expected 0 0 0", name, busy, frame_done, plot);
        end
    endtask

    task automatic set_all(input bit en);
        for (int i = 0; i < 4; i++) begin
            in_x[i] = 20 + 30*i; in_y[i] = 10 + 20*i; in_c[i] = i + 1; in_en[i] = en;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; pause = 1'b0; frame_start = 1'b0;
        set_all(1'b0);
        drive_inputs();
        step(); step();
        reset = 1'b0;
        model_reset();
        n_tests++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || plot !== 1'b0 ||
            x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%0d done=%0d plot=%0d x=%0d y=%0d c=%0d expected all 0",
                     busy, frame_done, plot, x, y, colour);
        end
    endtask

    task automatic test_first_frame();
        set_all(1'b1);
        in_x[0] = 10; in_y[0] = 20; in_c[0] = 4;
        run_frame(-1, 0, -1, -1);
    endtask

    task automatic test_moved();
        set_all(1'b1);
        in_x[0] = 11; in_y[0] = 20; in_c[0] = 4;
        run_frame(-1, 0, -1, -1);
    endtask

    task automatic test_corner_clip();
        set_all(1'b0);
        in_x[1] = 158; in_y[1] = 118; in_c[1] = 6; in_en[1] = 1'b1;
        run_frame(-1, 0, -1, -1);
    endtask

    task automatic test_pause();
        set_all(1'b1);
        run_frame(5, 10, -1, -1);
    endtask

    task automatic test_busy_ignore();
        set_all(1'b1);
        in_x[2] = 155; in_y[3] = 117;
        run_frame(-1, 0, 3, -1);
        check_idle("no_extra_frame_a");
        check_idle("no_extra_frame_b");
    endtask

    task automatic test_pause_idle();
        pause = 1'b1;
        frame_start = 1'b1;
        check_idle("paused_start_a");
        check_idle("paused_start_b");
        frame_start = 1'b0;
        pause = 1'b0;
        check_idle("paused_start_c");
    endtask

    task automatic test_abort();
        set_all(1'b1);
        run_frame(-1, 0, -1, 10);
        set_all(1'b1);
        run_frame(-1, 0, -1, -1);
    endtask

    task automatic test_back_to_back_random();
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 4; i++) begin
                in_x[i] = $urandom_range(0, 255); in_y[i] = $urandom_range(0, 127);
                in_c[i] = $urandom_range(0, 7);   in_en[i] = 1'($urandom_range(0, 1));
            end
            if (f % 2 == 1) run_frame($urandom_range(0, 3), $urandom_range(1, 4), -1, -1);
            else            run_frame(-1, 0, -1, -1);
        end
        check_idle("after_random");
    endtask

    initial begin
        sprite_x = '0; sprite_y = '0; sprite_colour = '0; sprite_en = '0;
        test_reset();
        test_first_frame();
        test_moved();
        test_corner_clip();
        test_pause();
        test_busy_ignore();
        test_pause_idle();
        test_abort();
        test_back_to_back_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_frame_plotter.md
Name: sprite_frame_plotter

Overview:
- Parametrised draw sequencer that turns a per-frame snapshot of NUM_SPRITES rectangular sprites into a stream of (x, y, colour, plot) triplets for the VGA adapter.
- Each frame first erases every sprite at its previous position, then draws every sprite at its new position.
- Successor to the fixed single-ship/single-enemy datapath; generalises sprite count, sprite size and screen size, and adds clipping, pause-freeze and a start/busy/done handshake.

Parameters:
- NUM_SPRITES, 4, number of sprite slots.
- SPR_W, 4, sprite width in pixels.
- SPR_H, 4, sprite height in pixels.
- X_BITS, 8, x coordinate width.
- Y_BITS, 7, y coordinate width.
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped.
- BG_COLOUR, 3'b000, colour used for erase.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- pause  input  1  freezes sequencing while high.
- frame_start  input  1  request to render one frame; sampled only in IDLE.
- sprite_x  input  NUM_SPRITES*X_BITS  top-left x per sprite; sprite i occupies bits [i*X_BITS +: X_BITS].
- sprite_y  input  NUM_SPRITES*Y_BITS  top-left y per sprite.
- sprite_colour  input  NUM_SPRITES*3  RGB per sprite.
- sprite_en  input  NUM_SPRITES  sprite visible.
- busy  output  1  high from frame acceptance until frame_done.
- frame_done  output  1  one-cycle pulse when a frame completes.
- x  output  X_BITS  pixel x.
- y  output  Y_BITS  pixel y.
- colour  output  3  pixel colour.
- plot  output  1  write strobe for the VGA adapter.

Behaviour:
- Reset (synchronous, highest priority, including mid-frame):
  - state = IDLE.
  - busy, frame_done, plot = 0; x, y, colour = 0.
  - Previous-frame snapshot: prev_en = 0, all other prev_* = 0.
  - Consequence: the first frame after reset erases nothing. An aborted frame leaves the screen as-is.
- States: IDLE, ERASE, DRAW, DONE.
- IDLE:
  - At the edge where frame_start = 1 and pause = 0, latch sprite_x/y/colour/en into the new snapshot, set busy = 1, go to ERASE with sprite index 0 and pixel counters (col, row) = (0, 0).
  - frame_start is ignored in every other state and when pause = 1.
  - Inputs may change freely after acceptance.
- Slots:
  - Each edge in ERASE or DRAW with pause = 0 emits one registered slot and advances the counters.
  - Enabled sprite: SPR_W*SPR_H slots in row-major order (col fastest), pixel = (base_x + col, base_y + row).
  - Disabled sprite: exactly 1 slot with plot = 0.
  - Sprite index increments after its last slot. ERASE covers indices 0..NUM_SPRITES-1, then DRAW covers 0..NUM_SPRITES-1.
- ERASE uses the prev_* snapshot with colour = BG_COLOUR. DRAW uses the new snapshot with colour = sprite_colour[i].
- Arithmetic and clipping:
  - Pixel coordinates are computed at X_BITS+1 / Y_BITS+1 width.
  - plot = 1 only if the sprite is enabled, x < SCREEN_W and y < SCREEN_H.
  - Clipped slots still consume a cycle and emit plot = 0; no coordinate wrap-around ever reaches the outputs.
- Pause:
  - While pause = 1 in ERASE or DRAW: counters and state hold, plot = 0, x/y/colour hold, busy stays 1.
  - On release, sequencing resumes at the held slot; no pixel is skipped or repeated.
- DONE:
  - The edge after the last DRAW slot sets plot = 0, frame_done = 1, busy = 0, copies the new snapshot into prev_*, and moves to IDLE.
  - frame_done clears on the following edge.
  - frame_start may be accepted on the same edge frame_done drops (back-to-back frames).
- Latency: with no pause, frame_done is asserted exactly S+1 edges after the accepting edge, where S = total slots (erase + draw).

Test Plan:
- Reset, then frame_start with all 4 sprites enabled; sprite0 = (10,20), colour 3'b100 -> 4 erase slots with plot = 0, then 64 draw plots; sprite0 plots x 10..13 × y 20..23 in row-major order with colour 4; frame_done 69 edges after acceptance.
- Second frame, sprite0 moved to (11,20) -> first 16 plots are BG_COLOUR over (10..13, 20..23), then the draw phase places sprite0 at x 11..14; 128 slots total; frame_done at edge 129.
- sprite1 at (158,118), others disabled -> during draw exactly 4 plots, at (158,118), (159,118), (158,119), (159,119); the remaining 12 of its slots have plot = 0.
- Pause held for 10 cycles starting at draw slot 5 -> plot = 0 and outputs frozen for 10 cycles, then slot 5 is emitted; frame_done is delayed by exactly 10 cycles.
- frame_start pulsed while busy -> ignored, no extra frame. Reset asserted mid-DRAW -> next edge busy = 0, plot = 0; following frame performs no erase plots (4 slots with plot = 0).
